// File: rtl/isa_pkg.sv
// Shared ARM-subset ISA constants used by the encoder and the control unit.
// Also holds the encoder FSM state type and a cond legality helper.
package isa_pkg;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] MOV = 3'b010;
    localparam logic [2:0] CMP = 3'b011;
    localparam logic [2:0] STR = 3'b100;
    localparam logic [2:0] LDR = 3'b101;
    localparam logic [2:0] B   = 3'b110;
    localparam logic [2:0] BL  = 3'b111;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } enc_state_e;

    function automatic logic cond_legal(input logic [3:0] c);
        return (c == COND_AL) || (c == COND_EQ) || (c == COND_NE);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: symbolic instruction -> 32-bit word.
// Field layout matches what the control-unit decoder consumes.
module instr_pack
    import isa_pkg::*;
(
    input  logic [2:0]  code_i,
    input  logic [3:0]  cond_i,
    input  logic        imm_i,
    input  logic        s_i,
    input  logic        u_i,
    input  logic [3:0]  rn_i,
    input  logic [3:0]  rd_i,
    input  logic [3:0]  rm_i,
    input  logic [11:0] imm12_i,
    input  logic [23:0] imm24_i,
    output logic [31:0] word_o
);

    logic [3:0]  cmd;
    logic        s_bit;
    logic [3:0]  rn_f;
    logic [3:0]  rd_f;
    logic [11:0] src2;

    // Per-opcode field selection, then concatenation by instruction class
    always_comb begin
        cmd    = CMD_ADD;
        s_bit  = s_i;
        rn_f   = rn_i;
        rd_f   = rd_i;
        src2   = imm_i ? imm12_i : {8'h00, rm_i};
        word_o = '0;
        unique case (code_i)
            ADD: cmd = CMD_ADD;
            SUB: cmd = CMD_SUB;
            MOV: begin
                cmd  = CMD_MOV;
                rn_f = 4'h0;
            end
            CMP: begin
                cmd   = CMD_CMP;
                s_bit = 1'b1;
                rd_f  = 4'h0;
            end
            STR, LDR, B, BL: cmd = CMD_ADD;
        endcase
        unique case (code_i)
            ADD, SUB, MOV, CMP:
                word_o = {cond_i, OP_DP, imm_i, cmd, s_bit,
                          rn_f, rd_f, src2};
            STR, LDR:
                word_o = {cond_i, OP_MEM, ~imm_i, 1'b1, u_i, 2'b00,
                          (code_i == LDR), rn_f, rd_f, src2};
            B, BL:
                word_o = {cond_i, OP_BR, 1'b1, code_i[0], imm24_i};
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder / program loader: one handshake -> one imem write.
// Two-state FSM; words land at an auto-incrementing address until full.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              enc_valid,
    output logic              enc_ready,
    input  logic [2:0]        enc_code,
    input  logic [3:0]        enc_cond,
    input  logic              enc_imm,
    input  logic              enc_s,
    input  logic              enc_u,
    input  logic [3:0]        enc_rn,
    input  logic [3:0]        enc_rd,
    input  logic [3:0]        enc_rm,
    input  logic [11:0]       enc_imm12,
    input  logic [23:0]       enc_imm24,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err_cond
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

    enc_state_e        state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              full_q;
    logic              err_q;
    logic [31:0]       packed_w;
    logic              accept;

    instr_pack u_pack (
        .code_i  (enc_code),
        .cond_i  (enc_cond),
        .imm_i   (enc_imm),
        .s_i     (enc_s),
        .u_i     (enc_u),
        .rn_i    (enc_rn),
        .rd_i    (enc_rd),
        .rm_i    (enc_rm),
        .imm12_i (enc_imm12),
        .imm24_i (enc_imm24),
        .word_o  (packed_w)
    );

    // rst_n gates ready so nothing is accepted while held in reset
    assign enc_ready = rst_n && (state_q == IDLE) && !full_q && !clear;
    assign accept    = enc_valid && enc_ready;

    // Word count: bumps after each write; clear rewinds, even mid-write
    always_comb begin
        count_d = count_q;
        if (state_q == WRITE) begin
            count_d = clear ? '0 : count_q + ONE_C;
        end else if (clear) begin
            count_d = '0;
        end
    end

    // Handshake FSM with registered write port and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (cond_legal(enc_cond)) begin
                            state_q <= WRITE;
                            we_q    <= 1'b1;
                            addr_q  <= count_q[ADDR_W-1:0];
                            wdata_q <= packed_w;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                WRITE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = full_q;
    assign err_cond   = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder against an ISA-level reference model.
// Directed vectors pin the model with hand-encoded words.
module tb_instr_encoder;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              enc_valid = 1'b0;
    logic              enc_ready;
    logic [2:0]        enc_code = '0;
    logic [3:0]        enc_cond = 4'hE;
    logic              enc_imm = 1'b0;
    logic              enc_s = 1'b0;
    logic              enc_u = 1'b0;
    logic [3:0]        enc_rn = '0;
    logic [3:0]        enc_rd = '0;
    logic [3:0]        enc_rm = '0;
    logic [11:0]       enc_imm12 = '0;
    logic [23:0]       enc_imm24 = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err_cond;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    // model state
    int          m_count = 0;
    bit          m_busy = 1'b0;
    bit          m_err = 1'b0;
    int          m_addr = 0;
    logic [31:0] m_wdata = '0;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .enc_valid(enc_valid), .enc_ready(enc_ready),
        .enc_code(enc_code), .enc_cond(enc_cond),
        .enc_imm(enc_imm), .enc_s(enc_s), .enc_u(enc_u),
        .enc_rn(enc_rn), .enc_rd(enc_rd), .enc_rm(enc_rm),
        .enc_imm12(enc_imm12), .enc_imm24(enc_imm24),
        .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .count(count),
        .full(full), .err_cond(err_cond)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ISA rules written as plain arithmetic on field positions
    function automatic logic [31:0] ref_word(
        input int code, input int cond, input int imm, input int s,
        input int u, input int rn, input int rd, input int rm,
        input int i12, input int i24);
        int cmds[4];
        longint w;
        int lo;
        cmds = '{4, 2, 13, 10};
        lo = (imm != 0) ? i12 : rm;
        w = longint'(cond) * (1 << 28);
        if (code < 4) begin
            if (code == 3) s = 1;
            if (code == 2) rn = 0;
            if (code == 3) rd = 0;
            w += imm * (1 << 25) + cmds[code] * (1 << 21) + s * (1 << 20)
               + rn * (1 << 16) + rd * (1 << 12) + lo;
        end else if (code < 6) begin
            w += (1 << 26) + (1 - imm) * (1 << 25) + (1 << 24)
               + u * (1 << 23) + (code - 4) * (1 << 20)
               + rn * (1 << 16) + rd * (1 << 12) + lo;
        end else begin
            w += 5 * (1 << 25) + (code - 6) * (1 << 24) + i24;
        end
        return w[31:0];
    endfunction

    function automatic bit legal(input int c);
        return c == 14 || c == 0 || c == 1;
    endfunction

    // Reference model: one write per accepted legal request
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_count <= 0;
            m_err   <= 1'b0;
        end else begin
            m_err  <= 1'b0;
            m_busy <= 1'b0;
            if (m_busy) begin
                m_count <= clear ? 0 : m_count + 1;
            end else if (clear) begin
                m_count <= 0;
            end else if (enc_valid && m_count != DEPTH) begin
                if (legal(int'(enc_cond))) begin
                    m_busy  <= 1'b1;
                    m_addr  <= m_count;
                    m_wdata <= ref_word(int'(enc_code), int'(enc_cond),
                        int'(enc_imm), int'(enc_s), int'(enc_u),
                        int'(enc_rn), int'(enc_rd), int'(enc_rm),
                        int'(enc_imm12), int'(enc_imm24));
                end else begin
                    m_err <= 1'b1;
                end
            end
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("ready", 32'(enc_ready), 32'(rst_n && !m_busy
                && m_count != DEPTH && !clear));
            cmp("we", 32'(imem_we), 32'(m_busy));
            if (m_busy) begin
                cmp("addr", 32'(imem_addr), 32'(m_addr));
                cmp("wdata", imem_wdata, m_wdata);
            end
            cmp("count", 32'(count), 32'(m_count));
            cmp("full", 32'(full), 32'(m_count == DEPTH));
            cmp("err", 32'(err_cond), 32'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] c, input logic [3:0] cd,
        input logic im, input logic s, input logic u, input logic [3:0] rn,
        input logic [3:0] rd, input logic [3:0] rm, input logic [11:0] i12,
        input logic [23:0] i24);
        enc_code = c; enc_cond = cd; enc_imm = im; enc_s = s; enc_u = u;
        enc_rn = rn; enc_rd = rd; enc_rm = rm;
        enc_imm12 = i12; enc_imm24 = i24;
    endtask

    // Send one request, check the write that follows it
    task automatic send(input logic [31:0] exp_w, input int exp_a);
        enc_valid = 1'b1;
        step();
        enc_valid = 1'b0;
        cmp("lit_we", 32'(imem_we), 32'd1);
        cmp("lit_wdata", imem_wdata, exp_w);
        cmp("lit_addr", 32'(imem_addr), 32'(exp_a));
        step();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        int writes;
        int cnt0;
        logic [3:0] conds[3];
        conds = '{4'hE, 4'h0, 4'h1};

        chk_en = 1'b1;
        step();
        step();
        cmp("rst_ready", 32'(enc_ready), 32'd0);
        cmp("rst_we", 32'(imem_we), 32'd0);
        cmp("rst_addr", 32'(imem_addr), 32'd0);
        cmp("rst_wdata", imem_wdata, 32'd0);
        cmp("rst_count", 32'(count), 32'd0);
        cmp("rst_full", 32'(full), 32'd0);
        rst_n = 1'b1;
        step();
        cmp("post_rst_ready", 32'(enc_ready), 32'd1);

        set_req(3'b000, 4'hE, 0, 0, 0, 4'd2, 4'd1, 4'd3, 12'h0, 24'h0);
        send(32'hE0821003, 0);
        cmp("lit_count1", 32'(count), 32'd1);

        pulse_clear();
        set_req(3'b001, 4'hE, 1, 1, 0, 4'd1, 4'd1, 4'd0, 12'h005, 24'h0);
        send(32'hE2511005, 0);
        set_req(3'b011, 4'hE, 1, 0, 0, 4'd0, 4'd0, 4'd0, 12'h000, 24'h0);
        send(32'hE3500000, 1);
        set_req(3'b010, 4'hE, 0, 0, 0, 4'd0, 4'hF, 4'hE, 12'h0, 24'h0);
        send(32'hE1A0F00E, 2);

        pulse_clear();
        set_req(3'b101, 4'hE, 1, 0, 1, 4'd0, 4'd2, 4'd0, 12'h008, 24'h0);
        send(32'hE5902008, 0);
        set_req(3'b100, 4'hE, 1, 0, 0, 4'd0, 4'd2, 4'd0, 12'h004, 24'h0);
        send(32'hE5002004, 1);

        pulse_clear();
        set_req(3'b111, 4'h0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 12'h0, 24'h000010);
        send(32'h0B000010, 0);
        set_req(3'b110, 4'h1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 12'h0, 24'hFFFFFE);
        send(32'h1AFFFFFE, 1);

        // illegal cond: error pulse, no write
        cnt0 = int'(count);
        set_req(3'b000, 4'hA, 0, 0, 0, 4'd2, 4'd1, 4'd3, 12'h0, 24'h0);
        enc_valid = 1'b1;
        step();
        enc_valid = 1'b0;
        cmp("lit_err", 32'(err_cond), 32'd1);
        cmp("lit_err_we", 32'(imem_we), 32'd0);
        step();
        cmp("lit_err_drop", 32'(err_cond), 32'd0);
        cmp("lit_err_count", 32'(count), 32'(cnt0));

        // back-to-back until full
        pulse_clear();
        set_req(3'b000, 4'hE, 0, 0, 0, 4'd2, 4'd1, 4'd3, 12'h0, 24'h0);
        enc_valid = 1'b1;
        writes = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (imem_we) writes++;
        end
        cmp("lit_writes", 32'(writes), 32'(DEPTH));
        cmp("lit_full", 32'(full), 32'd1);
        cmp("lit_full_ready", 32'(enc_ready), 32'd0);
        cmp("lit_full_count", 32'(count), 32'(DEPTH));
        clear = 1'b1;
        step();
        clear = 1'b0;
        cmp("lit_clr_count", 32'(count), 32'd0);
        step();
        enc_valid = 1'b0;
        cmp("lit_clr_we", 32'(imem_we), 32'd1);
        cmp("lit_clr_addr", 32'(imem_addr), 32'd0);
        step();

        // reset during WRITE drops the strobe at once
        enc_valid = 1'b1;
        step();
        enc_valid = 1'b0;
        cmp("lit_mid_we", 32'(imem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        cmp("lit_rst_we", 32'(imem_we), 32'd0);
        cmp("lit_rst_count", 32'(count), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            enc_valid = ($urandom % 4) != 0;
            clear     = ($urandom % 12) == 0;
            enc_code  = 3'($urandom);
            enc_cond  = (($urandom % 8) == 0) ? 4'($urandom)
                                              : conds[$urandom % 3];
            enc_imm   = 1'($urandom);
            enc_s     = 1'($urandom);
            enc_u     = 1'($urandom);
            enc_rn    = 4'($urandom);
            enc_rd    = 4'($urandom);
            enc_rm    = 4'($urandom);
            enc_imm12 = 12'($urandom);
            enc_imm24 = 24'($urandom);
            step();
        end
        enc_valid = 1'b0;
        clear = 1'b0;
        step();
        step();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
